countdown_timer_param: RTL and testbench

//  Parametrised, single-clock MM:SS countdown timer with a settable preset.

---
 rtl/timer_pkg.sv | 44 ++++
 rtl/countdown_timer_param_if.sv | 31 +++
 rtl/countdown_timer_param_bcd_digit_pair.sv | 35 +++
 rtl/countdown_timer_param.sv | 134 +++++++++++++
 tb/tb_countdown_timer_param.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared types and BCD helpers for the MM:SS countdown timer.
// Holds the 2-bit FSM encoding, the BCD digit type and pair inc/dec functions.
package timer_pkg;

   typedef logic [3:0] bcd_t;
   typedef logic [1:0] state_t;

   localparam state_t ST_SET     = 2'd0;
   localparam state_t ST_PAUSE   = 2'd1;
   localparam state_t ST_RUN     = 2'd2;
   localparam state_t ST_EXPIRED = 2'd3;

   // +1 on a two-digit BCD value, wrapping max -> 00
   function automatic logic [7:0] bcd_pair_inc_wrap(
      input logic [7:0] val,
      input logic [7:0] max
   );
      logic [7:0] r;
      if (val >= max)
         r = 8'h00;
      else if (val[3:0] == 4'd9)
         r = {val[7:4] + 4'd1, 4'd0};
      else
         r = {val[7:4], val[3:0] + 4'd1};
      return r;
   endfunction

   // -1 on a two-digit BCD value; returns {borrow, value}.
   // Borrow is set exactly when val is 00, which then wraps to {hi_wrap,9}.
   function automatic logic [8:0] bcd_pair_dec(
      input logic [7:0] val,
      input bcd_t       hi_wrap
   );
      logic [8:0] r;
      if (val[3:0] != 4'd0)
         r = {1'b0, val[7:4], val[3:0] - 4'd1};
      else if (val[7:4] != 4'd0)
         r = {1'b0, val[7:4] - 4'd1, 4'd9};
      else
         r = {1'b1, hi_wrap, 4'd9};
      return r;
   endfunction

endpackage

// File: rtl/countdown_timer_param_if.sv
// Control/display bundle of the countdown timer.
// master: tick_en, setting, set_sec, set_min, run out; val0..3, led, done, running in.
interface countdown_timer_param_if #(
   parameter int LED_W = 16
);
   import timer_pkg::*;

   logic             tick_en;
   logic             setting;
   logic             set_sec;
   logic             set_min;
   logic             run;
   bcd_t             val0;
   bcd_t             val1;
   bcd_t             val2;
   bcd_t             val3;
   logic [LED_W-1:0] led;
   logic             done;
   logic             running;

   modport master (
      output tick_en, setting, set_sec, set_min, run,
      input  val0, val1, val2, val3, led, done, running
   );

   modport slave (
      input  tick_en, setting, set_sec, set_min, run,
      output val0, val1, val2, val3, led, done, running
   );

endinterface

// File: rtl/countdown_timer_param_bcd_digit_pair.sv
// Two-digit BCD register: load, inc with wrap at MAX, dec with borrow.
// Ports: clk, rst_n (sync, low), load/load_val, inc, dec, q, borrow (q==00).
module bcd_digit_pair
   import timer_pkg::*;
#(
   parameter logic [7:0] MAX     = 8'h59,
   parameter bcd_t       HI_WRAP = 4'd5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       inc,
   input  logic       dec,
   output logic [7:0] q,
   output logic       borrow
);

   logic [8:0] dec_r;

   assign dec_r  = bcd_pair_dec(q, HI_WRAP);
   assign borrow = dec_r[8];

   always_ff @(posedge clk) begin
      if (!rst_n)
         q <= 8'h00;
      else if (load)
         q <= load_val;
      else if (inc)
         q <= bcd_pair_inc_wrap(q, MAX);
      else if (dec)
         q <= dec_r[7:0];
   end

endmodule

// File: rtl/countdown_timer_param.sv
// MM:SS countdown timer with settable preset, run/pause and a done pulse.
// Ports: clk, rst_n (sync, low), bus (slave). AUTO_RELOAD_EN: periodic reload.
module countdown_timer_param
   import timer_pkg::*;
#(
   parameter logic [7:0] MIN_MAX = 8'h23,
   parameter logic [7:0] SEC_MAX = 8'h59,
   parameter int         LED_W   = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   countdown_timer_param_if.slave bus
);

   state_t           state;
   state_t           nxt;
   logic [7:0]       p_sec;
   logic [7:0]       p_min;
   logic [7:0]       p_sec_nxt;
   logic [7:0]       p_min_nxt;
   logic [7:0]       c_sec;
   logic [7:0]       c_min;
   logic             sec_zero;
   logic             min_zero;
   logic             run_tick;
   logic             expire;
   logic             reload;
   logic             load;
   logic [LED_W-1:0] led_q;
   logic             done_q;
   logic             running_q;

   always_comb begin
      p_sec_nxt = p_sec;
      p_min_nxt = p_min;
      if (bus.setting && bus.set_sec)
         p_sec_nxt = bcd_pair_inc_wrap(p_sec, SEC_MAX);
      if (bus.setting && bus.set_min)
         p_min_nxt = bcd_pair_inc_wrap(p_min, MIN_MAX);
   end

   // a zero count in RUN only exists for one cycle after an auto-reload expiry
   assign run_tick = (state == ST_RUN) && bus.tick_en && !bus.setting
                     && !(sec_zero && min_zero);
   assign expire   = run_tick && min_zero && (c_sec == 8'h01);

`ifdef AUTO_RELOAD_EN
   assign reload = (state == ST_RUN) && !bus.setting
                   && sec_zero && min_zero;
`else
   assign reload = 1'b0;
`endif

   // in SET the count tracks the next preset so val* shows edits at once
   assign load = bus.setting || reload;

   bcd_digit_pair #(
      .MAX     (SEC_MAX),
      .HI_WRAP (4'd5)
   ) u_sec (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_val (p_sec_nxt),
      .inc      (1'b0),
      .dec      (run_tick),
      .q        (c_sec),
      .borrow   (sec_zero)
   );

   bcd_digit_pair #(
      .MAX     (MIN_MAX),
      .HI_WRAP (4'd9)
   ) u_min (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_val (p_min_nxt),
      .inc      (1'b0),
      .dec      (run_tick && sec_zero),
      .q        (c_min),
      .borrow   (min_zero)
   );

   always_comb begin
      nxt = state;
      if (bus.setting) begin
         nxt = ST_SET;
      end else begin
         case (state)
            ST_SET:
               if (p_sec == 8'h00 && p_min == 8'h00)
                  nxt = ST_EXPIRED;
               else
                  nxt = bus.run ? ST_RUN : ST_PAUSE;
            ST_PAUSE, ST_RUN:
               nxt = bus.run ? ST_RUN : ST_PAUSE;
            default:
               nxt = ST_EXPIRED;
         endcase
`ifndef AUTO_RELOAD_EN
         if (expire)
            nxt = ST_EXPIRED;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_EXPIRED;
         p_sec     <= 8'h00;
         p_min     <= 8'h00;
         led_q     <= '1;
         done_q    <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state     <= nxt;
         p_sec     <= p_sec_nxt;
         p_min     <= p_min_nxt;
         led_q     <= {LED_W{(nxt == ST_EXPIRED) || expire}};
         done_q    <= expire;
         running_q <= (nxt == ST_RUN);
      end
   end

   assign bus.val0    = c_sec[3:0];
   assign bus.val1    = c_sec[7:4];
   assign bus.val2    = c_min[3:0];
   assign bus.val3    = c_min[7:4];
   assign bus.led     = led_q;
   assign bus.done    = done_q;
   assign bus.running = running_q;

endmodule

// File: tb/tb_countdown_timer_param.sv
// Testbench for countdown_timer_param: vector table, directed corners,
// and randomized stimulus against a seconds-based reference model.
module tb_countdown_timer_param;

   localparam int LED_W     = 16;
   localparam int MIN_MAX_I = 23;
   localparam int SEC_MAX_I = 59;
`ifdef AUTO_RELOAD_EN
   localparam bit RELOAD = 1'b1;
`else
   localparam bit RELOAD = 1'b0;
`endif

   localparam int M_SET   = 0;
   localparam int M_PAUSE = 1;
   localparam int M_RUN   = 2;
   localparam int M_EXP   = 3;

   typedef struct {
      bit          s;
      bit          ss;
      bit          sm;
      bit          rn;
      bit          tk;
      logic [15:0] val;
      bit          led;
      bit          done;
      bit          running;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;

   int m_pmin, m_psec, m_cnt, m_mode;
   bit m_done;

   countdown_timer_param_if #(.LED_W(LED_W)) bus ();

   countdown_timer_param #(
      .MIN_MAX (8'h23),
      .SEC_MAX (8'h59),
      .LED_W   (LED_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // reference: count held as total seconds, presets as plain integers
   function automatic void model_step(bit r, bit s, bit ss, bit sm,
                                      bit rn, bit tk);
      m_done = 1'b0;
      if (!r) begin
         m_pmin = 0;
         m_psec = 0;
         m_cnt  = 0;
         m_mode = M_EXP;
      end else if (s) begin
         if (ss) m_psec = (m_psec == SEC_MAX_I) ? 0 : m_psec + 1;
         if (sm) m_pmin = (m_pmin == MIN_MAX_I) ? 0 : m_pmin + 1;
         m_cnt  = m_pmin * 60 + m_psec;
         m_mode = M_SET;
      end else begin
         case (m_mode)
            M_SET:
               m_mode = (m_cnt == 0) ? M_EXP : (rn ? M_RUN : M_PAUSE);
            M_PAUSE:
               m_mode = rn ? M_RUN : M_PAUSE;
            M_RUN: begin
               if (RELOAD && m_cnt == 0) begin
                  m_cnt = m_pmin * 60 + m_psec;
               end else if (tk) begin
                  m_cnt = m_cnt - 1;
                  if (m_cnt == 0) m_done = 1'b1;
               end
               m_mode = rn ? M_RUN : M_PAUSE;
               if (m_done && !RELOAD) m_mode = M_EXP;
            end
            default: ;
         endcase
      end
   endfunction

   function automatic logic [15:0] to_bcd(int t);
      int m;
      int s;
      m = t / 60;
      s = t % 60;
      return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   task automatic drive(bit r, bit s, bit ss, bit sm, bit rn, bit tk);
      rst_n       = r;
      bus.setting = s;
      bus.set_sec = ss;
      bus.set_min = sm;
      bus.run     = rn;
      bus.tick_en = tk;
      model_step(r, s, ss, sm, rn, tk);
      @(posedge clk);
      #1;
   endtask

   task automatic check(string nm, logic [15:0] ev, bit el, bit ed, bit er);
      logic [15:0]      av;
      logic [LED_W-1:0] el_v;
      av   = {bus.val3, bus.val2, bus.val1, bus.val0};
      el_v = {LED_W{el}};
      n_tests++;
      if (av !== ev || bus.led !== el_v || bus.done !== ed
          || bus.running !== er) begin
         n_fail++;
         $display("FAIL %s: got val=%h led=%h done=%b running=%b, want val=%h led=%h done=%b running=%b",
                  nm, av, bus.led, bus.done, bus.running, ev, el_v, ed, er);
      end
   endtask

   task automatic check_model(string nm);
      check(nm, to_bcd(m_cnt), (m_mode == M_EXP) || m_done, m_done,
            m_mode == M_RUN);
   endtask

   vec_t tbl[16];
   bit   rn_r;

   initial begin
      tbl[0]  = '{1, 0, 0, 0, 0, 16'h0000, 0, 0, 0};
      tbl[1]  = '{1, 0, 1, 0, 0, 16'h0100, 0, 0, 0};
      tbl[2]  = '{1, 0, 1, 0, 0, 16'h0200, 0, 0, 0};
      tbl[3]  = '{1, 0, 1, 0, 0, 16'h0300, 0, 0, 0};
      tbl[4]  = '{1, 1, 0, 0, 0, 16'h0301, 0, 0, 0};
      tbl[5]  = '{1, 1, 0, 0, 0, 16'h0302, 0, 0, 0};
      tbl[6]  = '{1, 1, 0, 0, 0, 16'h0303, 0, 0, 0};
      tbl[7]  = '{1, 1, 0, 0, 0, 16'h0304, 0, 0, 0};
      tbl[8]  = '{1, 1, 0, 0, 0, 16'h0305, 0, 0, 0};
      tbl[9]  = '{0, 0, 0, 1, 0, 16'h0305, 0, 0, 1};
      tbl[10] = '{0, 0, 0, 1, 1, 16'h0304, 0, 0, 1};
      tbl[11] = '{0, 0, 0, 1, 1, 16'h0303, 0, 0, 1};
      tbl[12] = '{0, 0, 0, 1, 1, 16'h0302, 0, 0, 1};
      tbl[13] = '{0, 0, 0, 0, 0, 16'h0302, 0, 0, 0};
      tbl[14] = '{0, 0, 0, 0, 1, 16'h0302, 0, 0, 0};
      tbl[15] = '{1, 0, 0, 1, 1, 16'h0305, 0, 0, 0};

      // reset
      drive(0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      check("reset", 16'h0000, 1, 0, 0);

      // preset edit, run and ticks
      for (int i = 0; i < 16; i++) begin
         drive(1, tbl[i].s, tbl[i].ss, tbl[i].sm, tbl[i].rn, tbl[i].tk);
         check($sformatf("vec%0d", i), tbl[i].val, tbl[i].led,
               tbl[i].done, tbl[i].running);
      end

`ifndef AUTO_RELOAD_EN
      // 01:00 down to expiry
      drive(0, 0, 0, 0, 0, 0);
      drive(1, 1, 0, 1, 0, 0);
      drive(1, 0, 0, 0, 1, 0);
      check("t3_start", 16'h0100, 0, 0, 1);
      drive(1, 0, 0, 0, 1, 1);
      check("t3_borrow", 16'h0059, 0, 0, 1);
      for (int i = 0; i < 58; i++) drive(1, 0, 0, 0, 1, 1);
      check("t3_one", 16'h0001, 0, 0, 1);
      drive(1, 0, 0, 0, 1, 1);
      check("t3_expire", 16'h0000, 1, 1, 0);
      drive(1, 0, 0, 0, 1, 1);
      check("t3_done_once", 16'h0000, 1, 0, 0);
`else
      // periodic reload of 00:02
      drive(0, 0, 0, 0, 0, 0);
      drive(1, 1, 1, 0, 0, 0);
      drive(1, 1, 1, 0, 0, 0);
      drive(1, 0, 0, 0, 1, 0);
      check("t6_start", 16'h0002, 0, 0, 1);
      drive(1, 0, 0, 0, 1, 1);
      check("t6_one", 16'h0001, 0, 0, 1);
      drive(1, 0, 0, 0, 1, 1);
      check("t6_expire", 16'h0000, 1, 1, 1);
      drive(1, 0, 0, 0, 1, 0);
      check("t6_reload", 16'h0002, 0, 0, 1);
`endif

      // preset wrap
      drive(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 23; i++) drive(1, 1, 0, 1, 0, 0);
      check("t4_min_max", 16'h2300, 0, 0, 0);
      drive(1, 1, 0, 1, 0, 0);
      check("t4_min_wrap", 16'h0000, 0, 0, 0);
      for (int i = 0; i < 5; i++) drive(1, 1, 0, 1, 0, 0);
      for (int i = 0; i < 59; i++) drive(1, 1, 1, 0, 0, 0);
      check("t4_sec_max", 16'h0559, 0, 0, 0);
      drive(1, 1, 1, 0, 0, 0);
      check("t4_sec_wrap", 16'h0500, 0, 0, 0);
      drive(1, 1, 1, 1, 0, 0);
      check("t4_both", 16'h0601, 0, 0, 0);

      // pause ignores ticks; setting beats tick
      drive(0, 0, 0, 0, 0, 0);
      drive(1, 1, 0, 1, 0, 0);
      drive(1, 1, 0, 1, 0, 0);
      drive(1, 0, 0, 0, 1, 0);
      drive(1, 0, 0, 0, 1, 1);
      check("t5_run", 16'h0159, 0, 0, 1);
      drive(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) drive(1, 0, 0, 0, 0, 1);
      check("t5_pause", 16'h0159, 0, 0, 0);
      drive(1, 0, 0, 0, 1, 0);
      check("t5_resume", 16'h0159, 0, 0, 1);
      drive(1, 1, 0, 0, 1, 1);
      check("t5_set_tick", 16'h0200, 0, 0, 0);
      drive(1, 0, 0, 0, 1, 0);
      check("t5_rerun", 16'h0200, 0, 0, 1);

      // randomized against the model
      drive(0, 0, 0, 0, 0, 0);
      rn_r = 1'b0;
      for (int i = 0; i < 600; i++) begin
         bit r, s, ss, sm, tk;
         r  = ($urandom_range(0, 99) != 0);
         s  = ($urandom_range(0, 19) == 0);
         ss = s && ($urandom_range(0, 1) == 1);
         sm = s && ($urandom_range(0, 15) == 0);
         tk = ($urandom_range(0, 3) != 0);
         if (!tk && $urandom_range(0, 9) == 0) rn_r = !rn_r;
         drive(r, s, ss, sm, rn_r, tk);
         check_model($sformatf("rand%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
